// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared constants for the instruction fetch stage
package pc_fetch_pkg;
    localparam int PC_W = 32;
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;
    localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_0063;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
endpackage

// File: rtl/pc_fetch_sat_counter.sv
// sat_counter: enable-driven up counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);
    // count enabled cycles, holding once every bit is set
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (en && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and issue control with halt and misalignment fault
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              IMEM_WORDS = 128,
    parameter logic [31:0]     HALT_INSN  = HALT_INSN_DEFAULT
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] target,
    input  logic [31:0]     instr_in,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic [31:0]     instr_out,
    output logic            instr_valid,
    output logic            halted,
    output logic            fault,
    output logic [PC_W-1:0] fault_pc,
    output logic [31:0]     retired
);
    logic [1:0]      state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            oob, misalign, halt_det;

    // fetches past the end of instruction memory behave like the halt instruction
    always_comb begin
        oob         = 32'(pc[PC_W-1:2]) >= 32'(IMEM_WORDS);
        instr_valid = state == ST_RUN && !stall;
        misalign    = instr_valid && redirect && target[1:0] != 2'b00;
        halt_det    = instr_valid && (instr_in == HALT_INSN || oob);
        pc_plus4    = pc + 32'd4;
        instr_out   = instr_valid ? instr_in : NOP_INSN;
        halted      = state == ST_HALT;
        fault       = state == ST_FAULT;
        pc_nxt      = !instr_valid || misalign || halt_det ? pc : redirect ? target : pc_plus4;
        state_nxt   = state == ST_BOOT ? ST_RUN : !instr_valid ? state :
                      misalign ? ST_FAULT : halt_det ? ST_HALT : ST_RUN;
    end

    // architectural state: pc, fsm and the captured faulting target
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc       <= RESET_PC;
            state    <= ST_BOOT;
            fault_pc <= '0;
        end else begin
            pc       <= pc_nxt;
            state    <= state_nxt;
            fault_pc <= misalign ? target : fault_pc;
        end

    sat_counter #(.W(32)) u_retired (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (instr_valid),
        .count (retired)
    );
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: vector table with scoreboard for pc_fetch, plus saturation sequence
module tb_pc_fetch;
    localparam logic [31:0] N = 32'h0000_0013;
    localparam logic [31:0] A = 32'h0010_0093;
    localparam logic [31:0] H = 32'h0000_0063;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] instr_in = N;
    logic [31:0] pc, pc_plus4, instr_out, fault_pc, retired;
    logic        instr_valid, halted, fault;

    logic        sc_rst_n = 1'b0;
    logic        sc_en = 1'b0;
    logic [2:0]  sc_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst_n, stall, redirect;
        logic [31:0] target, instr;
        logic [31:0] pc, p4;
        logic        valid;
        logic [31:0] iout;
        logic        halted, fault;
        logic [31:0] fpc, ret;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    pc_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .target(target),
        .instr_in(instr_in), .pc(pc), .pc_plus4(pc_plus4), .instr_out(instr_out),
        .instr_valid(instr_valid), .halted(halted), .fault(fault), .fault_pc(fault_pc),
        .retired(retired)
    );

    sat_counter #(.W(3)) u_sc (.clk(clk), .rst_n(sc_rst_n), .en(sc_en), .count(sc_count));

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic s, logic d, logic [31:0] t, logic [31:0] i,
                                logic [31:0] p, logic [31:0] p4, logic v, logic [31:0] io,
                                logic h, logic f, logic [31:0] fp, logic [31:0] rt);
        vec_t x;
        x.rst_n = r; x.stall = s; x.redirect = d; x.target = t; x.instr = i;
        x.pc = p; x.p4 = p4; x.valid = v; x.iout = io; x.halted = h; x.fault = f;
        x.fpc = fp; x.ret = rt;
        return x;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(int idx, vec_t v);
        vec_t e;
        rst_n = v.rst_n; stall = v.stall; redirect = v.redirect;
        target = v.target; instr_in = v.instr;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk("pc", idx, pc, e.pc);
        chk("pc_plus4", idx, pc_plus4, e.p4);
        chk("instr_valid", idx, 32'(instr_valid), 32'(e.valid));
        chk("instr_out", idx, instr_out, e.iout);
        chk("halted", idx, 32'(halted), 32'(e.halted));
        chk("fault", idx, 32'(fault), 32'(e.fault));
        chk("fault_pc", idx, fault_pc, e.fpc);
        chk("retired", idx, retired, e.ret);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, boot, sequential fetch, stall, redirect, halting self-branch
        tbl.push_back(mk(0,0,0,0,N,        0,4,0,N,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,N,        0,4,0,N,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,N,        0,4,1,N,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,A,        4,8,1,A,0,0,0,1));
        tbl.push_back(mk(1,1,0,0,A,        8,32'hC,0,N,0,0,0,2));
        tbl.push_back(mk(1,1,1,32'h40,A,   8,32'hC,0,N,0,0,0,2));
        tbl.push_back(mk(1,0,1,32'h40,A,   8,32'hC,1,A,0,0,0,2));
        tbl.push_back(mk(1,0,0,0,N,        32'h40,32'h44,1,N,0,0,0,3));
        tbl.push_back(mk(1,0,1,32'h10,N,   32'h44,32'h48,1,N,0,0,0,4));
        tbl.push_back(mk(1,0,1,32'h10,H,   32'h10,32'h14,1,H,0,0,0,5));
        tbl.push_back(mk(1,0,1,32'h80,N,   32'h10,32'h14,0,N,1,0,0,6));
        tbl.push_back(mk(1,1,1,32'h22,N,   32'h10,32'h14,0,N,1,0,0,6));
        // asynchronous reset out of HALT, then misaligned redirect beats halt detect
        tbl.push_back(mk(0,0,0,0,N,        0,4,0,N,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,N,        0,4,0,N,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'h22,N,   0,4,0,N,0,0,0,0));
        tbl.push_back(mk(1,0,1,32'h22,H,   0,4,1,H,0,0,0,0));
        tbl.push_back(mk(1,0,1,32'h40,N,   0,4,0,N,0,1,32'h22,1));
        tbl.push_back(mk(1,1,1,32'h80,H,   0,4,0,N,0,1,32'h22,1));
        // reset out of FAULT, run off the end of instruction memory
        tbl.push_back(mk(0,0,0,0,N,        0,4,0,N,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,N,        0,4,0,N,0,0,0,0));
        tbl.push_back(mk(1,0,1,32'h1FC,N,  0,4,1,N,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,N,        32'h1FC,32'h200,1,N,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,N,        32'h200,32'h204,1,N,0,0,0,2));
        tbl.push_back(mk(1,0,0,0,N,        32'h200,32'h204,0,N,1,0,0,3));
        // pc_plus4 wrap at the top of the address space
        tbl.push_back(mk(0,0,0,0,N,        0,4,0,N,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,N,        0,4,0,N,0,0,0,0));
        tbl.push_back(mk(1,0,1,32'hFFFF_FFFC,N, 0,4,1,N,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,N,        32'hFFFF_FFFC,0,1,N,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,N,        32'hFFFF_FFFC,0,0,N,1,0,0,2));

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(i, tbl[i]);

        // saturation on a narrow counter instance, then asynchronous clear
        sc_rst_n = 1'b1;
        sc_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("sat_count", i, 32'(sc_count), (i > 7) ? 32'd7 : 32'(i));
            @(posedge clk);
            #1;
        end
        sc_en = 1'b0;
        @(negedge clk);
        chk("sat_hold", 0, 32'(sc_count), 32'd7);
        #1;
        sc_rst_n = 1'b0;
        #1;
        chk("sat_async_clear", 0, 32'(sc_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
